mult_div_hilo: RTL and testbench

Multi-cycle multiply/divide unit with the architectural HI/LO register pair, sitting directly downstream of the execute-stage operand bus. It receives the same 32-bit S/T operands as the combinational multiplier and owns the HI/LO state that MFHI/MFLO read. Multiplies complete in one clock. Divides use a 32-iteration restoring divider, and `busy` holds the pipeline while the divider runs.

---
 rtl/mult_div_hilo.sv | 169 ++++++++++++++++
 tb/tb_mult_div_hilo.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mult_div_hilo.sv
// mult_div_hilo: single-cycle multiply, 32-step restoring divide, HI/LO register pair
// Optional feature: define MDU_DIV0_TRAP_EN to short-circuit divide-by-zero and raise div0.
module mult_div_hilo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] S,
    input  logic [W-1:0] T,
    output logic [W-1:0] HI,
    output logic [W-1:0] LO,
    output logic         busy,
    output logic         done,
    output logic         N,
    output logic         Z,
    output logic         div0
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state_q, state_d;
    logic [W-1:0] hi_q, hi_d, lo_q, lo_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic n_q, n_d, z_q, z_d, done_q, done_d, qneg_q, qneg_d, rneg_q, rneg_d;
`ifdef MDU_DIV0_TRAP_EN
    logic div0_q, div0_d, dz_q, dz_d;
`endif
    logic sgn;
    logic [2*W-1:0] prod;
    logic [W-1:0] s_mag, t_mag, quo_f, rem_f;
    logic [W:0] full, diff;
    // op[0] clear selects the signed flavour of both MULT and DIV
    assign sgn   = ~op[0];
    assign prod  = {{W{sgn & S[W-1]}}, S} * {{W{sgn & T[W-1]}}, T};
    assign s_mag = (sgn & S[W-1]) ? -S : S;
    assign t_mag = (sgn & T[W-1]) ? -T : T;
    // rem can reach 2*dvs-1 after the shift, so the trial subtract needs one extra bit
    assign full  = {rem_q, quo_q[W-1]};
    assign diff  = full - {1'b0, dvs_q};
    assign quo_f = qneg_q ? -quo_q : quo_q;
    assign rem_f = rneg_q ? -rem_q : rem_q;
    // next-state: command decode in IDLE, one restoring step per ITER cycle, sign fix-up in FIX
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        z_d     = z_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;
`ifdef MDU_DIV0_TRAP_EN
        div0_d  = div0_q;
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: if (start) begin
`ifdef MDU_DIV0_TRAP_EN
                div0_d = 1'b0;
`endif
                case (op)
                    3'b000, 3'b001: begin
                        {hi_d, lo_d} = prod;
                        n_d    = prod[2*W-1];
                        z_d    = prod == '0;
                        done_d = 1'b1;
                    end
                    3'b010, 3'b011: begin
                        quo_d   = s_mag;
                        dvs_d   = t_mag;
                        rem_d   = '0;
                        cnt_d   = '0;
                        qneg_d  = sgn & (S[W-1] ^ T[W-1]);
                        rneg_d  = sgn & S[W-1];
`ifdef MDU_DIV0_TRAP_EN
                        dz_d    = T == '0;
                        state_d = (T == '0) ? FIX : ITER;
`else
                        state_d = ITER;
`endif
                    end
                    3'b100:  hi_d = S;
                    3'b101:  lo_d = S;
                    default: ;
                endcase
            end
            ITER: begin
                rem_d   = diff[W] ? full[W-1:0] : diff[W-1:0];
                quo_d   = {quo_q[W-2:0], ~diff[W]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(W-1)) ? FIX : ITER;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
`ifdef MDU_DIV0_TRAP_EN
                if (dz_q) begin
                    div0_d = 1'b1;
                end else begin
                    lo_d = quo_f;
                    hi_d = rem_f;
                    n_d  = rem_f[W-1];
                    z_d  = {rem_f, quo_f} == '0;
                end
`else
                lo_d = quo_f;
                hi_d = rem_f;
                n_d  = rem_f[W-1];
                z_d  = {rem_f, quo_f} == '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    // state register; reset abandons any divide in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b1;
            done_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`ifdef MDU_DIV0_TRAP_EN
            div0_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            z_q     <= z_d;
            done_q  <= done_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`ifdef MDU_DIV0_TRAP_EN
            div0_q  <= div0_d;
            dz_q    <= dz_d;
`endif
        end
    end
    assign HI   = hi_q;
    assign LO   = lo_q;
    assign N    = n_q;
    assign Z    = z_q;
    assign done = done_q;
    assign busy = state_q != IDLE;
`ifdef MDU_DIV0_TRAP_EN
    assign div0 = div0_q;
`else
    assign div0 = 1'b0;
`endif
endmodule

// File: tb/tb_mult_div_hilo.sv
// tb_mult_div_hilo: directed vector table for MULT/MT* plus hand sequences for divides and reset
module tb_mult_div_hilo;
    logic        clk = 1'b0;
    logic        reset, start, busy, done, N, Z, div0;
    logic [2:0]  op;
    logic [31:0] S, T, HI, LO;
    int          total = 0, passed = 0;
    logic [31:0] m_hi, m_lo;
    logic        m_n, m_z;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] s, t, hi, lo;
        logic        n, z, dn;
    } vec_t;
    vec_t vecs[10];

    mult_div_hilo dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .S(S), .T(T),
        .HI(HI), .LO(LO), .busy(busy), .done(done), .N(N), .Z(Z), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run_div(input string nm, input logic [2:0] o, input logic [31:0] s, input logic [31:0] t,
                           input int inj, input int ecyc, input logic [31:0] elo, input logic [31:0] ehi,
                           input logic en, input logic ez, input logic ediv0);
        int n;
        @(negedge clk);
        op = o; S = s; T = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, " busy_at_k"}, {31'b0, busy}, 32'd1);
        n = 0;
        while (busy && n < 40) begin
            if (n == inj) begin
                op = 3'b100; S = 32'hDEAD_BEEF; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (n == 16) chk({nm, " hi_hold"}, HI, m_hi);
        end
        chk({nm, " busy_cycles"}, n, ecyc);
        chk({nm, " done"}, {31'b0, done}, 32'd1);
        chk({nm, " lo"}, LO, elo);
        chk({nm, " hi"}, HI, ehi);
        chk({nm, " n"}, {31'b0, N}, {31'b0, en});
        chk({nm, " z"}, {31'b0, Z}, {31'b0, ez});
        chk({nm, " div0"}, {31'b0, div0}, {31'b0, ediv0});
        m_lo = elo; m_hi = ehi; m_n = en; m_z = ez;
        @(posedge clk); #1;
        chk({nm, " done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{3'b000, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{3'b000, 32'd0,         32'h1234_5678, 32'h0,         32'h0,         1'b0, 1'b1, 1'b1};
        vecs[3] = '{3'b100, 32'h1234_5678, 32'd9,         32'h1234_5678, 32'h0,         1'b0, 1'b1, 1'b0};
        vecs[4] = '{3'b101, 32'h9ABC_DEF0, 32'd9,         32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0,         1'b0, 1'b0, 1'b1};
        vecs[6] = '{3'b000, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{3'b110, 32'd5,         32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0, 1'b0, 1'b1};
        vecs[9] = '{3'b001, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0,         1'b0, 1'b0, 1'b1};
        reset = 1'b1; start = 1'b0; op = 3'b000; S = '0; T = '0;
        #12;
        chk("rst hi", HI, 32'h0);
        chk("rst lo", LO, 32'h0);
        chk("rst nzbd", {28'b0, N, Z, busy, done}, 32'b0100);
        chk("rst div0", {31'b0, div0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op = vecs[i].op; S = vecs[i].s; T = vecs[i].t; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk($sformatf("vec%0d hi", i), HI, vecs[i].hi);
            chk($sformatf("vec%0d lo", i), LO, vecs[i].lo);
            chk($sformatf("vec%0d n", i), {31'b0, N}, {31'b0, vecs[i].n});
            chk($sformatf("vec%0d z", i), {31'b0, Z}, {31'b0, vecs[i].z});
            chk($sformatf("vec%0d done", i), {31'b0, done}, {31'b0, vecs[i].dn});
            chk($sformatf("vec%0d busy", i), {31'b0, busy}, 32'd0);
            m_hi = vecs[i].hi; m_lo = vecs[i].lo; m_n = vecs[i].n; m_z = vecs[i].z;
        end
        run_div("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, -1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_div("divu_100_7", 3'b011, 32'd100, 32'd7, 10, 33, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        run_div("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1, 33, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
        run_div("div_7_m2", 3'b010, 32'd7, 32'hFFFF_FFFE, -1, 33, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 1'b0);
`ifdef MDU_DIV0_TRAP_EN
        run_div("divu_5_0", 3'b011, 32'd5, 32'd0, -1, 1, m_lo, m_hi, m_n, m_z, 1'b1);
`else
        run_div("divu_5_0", 3'b011, 32'd5, 32'd0, -1, 33, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, 1'b0);
`endif
        run_div("divu_after", 3'b011, 32'd9, 32'd4, -1, 33, 32'd2, 32'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        op = 3'b010; S = 32'd1000; T = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        chk("midrst hi", HI, 32'h0);
        chk("midrst lo", LO, 32'h0);
        chk("midrst nzbd", {28'b0, N, Z, busy, done}, 32'b0100);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("midrst no_done", seen, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
